// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between the pipeline and alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0] alu_control;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic zero;
  logic err;
  modport master(output in_valid, a, b, alu_control, out_ready,
                 input in_ready, out_valid, result, zero, err);
  modport slave(input in_valid, a, b, alu_control, out_ready,
                output in_ready, out_valid, result, zero, err);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and iterative MUL/DIVU/REMU
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH),
  localparam int CW = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst,
  alu_seq_if.slave io
);
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0] OP_OR = 4'h4, OP_XOR = 4'h5, OP_SLL = 4'h6, OP_SRL = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8, OP_SLT = 4'h9, OP_SLTU = 4'hA, OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, mq_q, mq_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic zero_q, zero_d, err_q, err_d;
  logic accept, illegal, multi;
  logic [SHW-1:0] sh;
  logic [WIDTH-1:0] alu_res, single_res, it_acc, it_mq, fin;
  logic [WIDTH:0] rem_sh, diff;
  logic ge;
  assign io.in_ready = (state_q == IDLE) && !rst;
  assign io.out_valid = (state_q == DONE);
  assign io.result = result_q;
  assign io.zero = zero_q;
  assign io.err = err_q;
  assign accept = io.in_valid && io.in_ready;
  assign illegal = io.alu_control > OP_REMU;
  assign multi = (io.alu_control == OP_MUL) || (io.alu_control == OP_DIVU) || (io.alu_control == OP_REMU);
  assign sh = io.b[SHW-1:0];
  always_comb begin
    case (io.alu_control)
      OP_ADD:  alu_res = io.a + io.b;
      OP_SUB:  alu_res = io.a - io.b;
      OP_AND:  alu_res = io.a & io.b;
      OP_OR:   alu_res = io.a | io.b;
      OP_XOR:  alu_res = io.a ^ io.b;
      OP_SLL:  alu_res = io.a << sh;
      OP_SRL:  alu_res = io.a >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(io.a) >>> sh);
      OP_SLT:  alu_res = WIDTH'($signed(io.a) < $signed(io.b));
      OP_SLTU: alu_res = WIDTH'(io.a < io.b);
      default: alu_res = '0;
    endcase
  end
  assign single_res = illegal ? '0 : alu_res;
  // MUL: acc accumulates a shifted left, mq holds the multiplier shifted right.
  // DIV: acc is the partial remainder, mq shifts the dividend out and quotient bits in.
  assign rem_sh = {acc_q, mq_q[WIDTH-1]};
  assign diff = rem_sh - {1'b0, b_q};
  assign ge = !diff[WIDTH];
  assign it_acc = (op_q == OP_MUL) ? acc_q + (mq_q[0] ? a_q : '0)
                                   : (ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]);
  assign it_mq = (op_q == OP_MUL) ? mq_q >> 1 : {mq_q[WIDTH-2:0], ge};
  assign fin = (op_q == OP_DIVU) ? it_mq : it_acc;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    mq_d = mq_q;
    result_d = result_q;
    zero_d = zero_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = io.alu_control;
        a_d = io.a;
        b_d = io.b;
        if (multi) begin
          state_d = BUSY;
          cnt_d = CW'(WIDTH);
          acc_d = '0;
          mq_d = (io.alu_control == OP_MUL) ? io.b : io.a;
        end else begin
          state_d = DONE;
          result_d = single_res;
          zero_d = (single_res == '0);
          err_d = illegal;
        end
      end
      BUSY: begin
        acc_d = it_acc;
        mq_d = it_mq;
        a_d = a_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          result_d = fin;
          zero_d = (fin == '0);
          err_d = 1'b0;
        end
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      mq_q <= '0;
      result_q <= '0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      mq_q <= mq_d;
      result_q <= result_d;
      zero_q <= zero_d;
      err_q <= err_d;
    end
  end
endmodule
